// File: rtl/uop_arb_pkg.sv
// Shared types and defaults for the round-robin arbiter.
package uop_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int MAX_HOLD_DEFAULT = 8;

endpackage

// File: rtl/uop_rr_pick.sv
// Rotating-priority search: first set request at or after ptr, wrapping N-1 -> 0.
module uop_rr_pick #(
    parameter int N = 4,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           valid,
    output logic [IDW-1:0] idx
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IDW-1:0] w_off;
    logic [IDW:0]   w_sum;

    // Doubling the vector turns the wrap-around rotate into a plain slice.
    assign w_dbl = {req, req};

    always_comb begin
        w_rot = '0;
        for (int i = 0; i < N; i++) begin
            w_rot[i] = w_dbl[int'(ptr) + i];
        end
    end

    always_comb begin
        w_off = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDW'(i);
                valid = 1'b1;
            end
        end
    end

    assign w_sum = {1'b0, ptr} + {1'b0, w_off};
    assign idx   = (w_sum >= (IDW+1)'(N)) ? IDW'(w_sum - (IDW+1)'(N)) : w_sum[IDW-1:0];

endmodule

// File: rtl/uop_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, hold limit and turnaround gap.
module uop_rr_arbiter
    import uop_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
    localparam int IDW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           n_reset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0]  HOLD_LAST = CW'(MAX_HOLD - 1);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(N - 1);

    arb_state_t     r_state;
    logic [N-1:0]   r_gnt;
    logic [IDW-1:0] r_gnt_id;
    logic [IDW-1:0] r_ptr;
    logic [CW-1:0]  r_hold;
    logic           r_timeout;

    logic           w_valid;
    logic [IDW-1:0] w_idx;
    logic [IDW-1:0] w_next_ptr;
    logic           w_owner_req;

    uop_rr_pick #(.N(N)) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_valid),
        .idx   (w_idx)
    );

    assign w_owner_req = req[r_gnt_id];
    assign w_next_ptr  = (r_gnt_id == LAST_ID) ? '0 : r_gnt_id + IDW'(1);

    // Every release returns to IDLE, which guarantees the one-cycle gap and
    // moves the pointer past the old owner so it loses priority.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timeout <= 1'b0;
                    if (w_valid) begin
                        r_gnt    <= N'(1) << w_idx;
                        r_gnt_id <= w_idx;
                        r_hold   <= '0;
                        r_state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (!w_owner_req || (r_hold == HOLD_LAST)) begin
                        r_gnt     <= '0;
                        r_gnt_id  <= '0;
                        r_ptr     <= w_next_ptr;
                        r_timeout <= w_owner_req;
                        r_state   <= IDLE;
                    end else begin
                        r_hold <= r_hold + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign busy    = |r_gnt;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_uop_rr_arbiter.sv
// Self-checking bench: directed vector table, corner sequences and random traffic vs a reference model.
module tb_uop_rr_arbiter;

    localparam int NREQ = 4;
    localparam int MAXH = 8;
    localparam int STARVE_BOUND = NREQ * (MAXH + 1);

    logic       clk;
    logic       n_reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    int   mOwner;
    int   mPtr;
    int   mHeld;
    logic mTimeout;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] gntId;
        logic       busy;
        logic       timeout;
    } vec_t;

    vec_t vecs[18];
    int   waitCnt[NREQ];

    uop_rr_arbiter #(.N(NREQ), .MAX_HOLD(MAXH)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void modelReset();
        mOwner   = -1;
        mPtr     = 0;
        mHeld    = 0;
        mTimeout = 1'b0;
    endfunction

    // Reference behaviour: owner index, cycles held so far, search start point.
    function automatic void modelStep(input logic [3:0] r);
        if (mOwner < 0) begin
            mTimeout = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (mPtr + k) % NREQ;
                if (r[c] && mOwner < 0) begin
                    mOwner = c;
                    mHeld  = 1;
                end
            end
        end else if (!r[mOwner] || mHeld == MAXH) begin
            mTimeout = r[mOwner];
            mPtr     = (mOwner + 1) % NREQ;
            mOwner   = -1;
            mHeld    = 0;
        end else begin
            mHeld++;
        end
    endfunction

    function automatic logic [3:0] modelGnt();
        return (mOwner < 0) ? 4'b0000 : 4'(1 << mOwner);
    endfunction

    function automatic logic [1:0] modelId();
        return (mOwner < 0) ? 2'd0 : 2'(mOwner);
    endfunction

    task automatic checkOutput(input string name, input logic [3:0] eg, input logic [1:0] eid,
                               input logic eb, input logic et);
        checks++;
        if ({gnt, gnt_id, busy, timeout} !== {eg, eid, eb, et}) begin
            errors++;
            $display("[TB] FAIL %s: got gnt=%b id=%0d busy=%b to=%b, want gnt=%b id=%0d busy=%b to=%b",
                     name, gnt, gnt_id, busy, timeout, eg, eid, eb, et);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        modelStep(r);
        #1;
    endtask

    task automatic doReset();
        n_reset = 1'b0;
        req     = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        modelReset();
        #1;
        checkOutput("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] r;

        // Single requester, fairness and re-grant after the idle gap.
        vecs[0]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[3]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[4]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[5]  = '{4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[6]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[7]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[8]  = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[9]  = '{4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[10] = '{4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[11] = '{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[12] = '{4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[13] = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[14] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[15] = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[16] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[17] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

        doReset();
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].req);
            checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].gntId, vecs[i].busy, vecs[i].timeout);
        end

        // All requesting: full-length grants in pointer order, each ended by a timeout gap.
        doReset();
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < MAXH; c++) begin
                applyStimulus(4'b1111);
                checkOutput($sformatf("rr%0d_hold%0d", g, c), 4'(1 << (g % 4)), 2'(g % 4), 1'b1, 1'b0);
            end
            applyStimulus(4'b1111);
            checkOutput($sformatf("rr%0d_gap", g), 4'b0000, 2'd0, 1'b0, 1'b1);
        end

        // Owner 3 drops in the same cycle the limit is reached: plain release, ptr wraps.
        doReset();
        for (int c = 0; c < MAXH; c++) begin
            applyStimulus(4'b1000);
            checkOutput("lim_hold", 4'b1000, 2'd3, 1'b1, 1'b0);
        end
        applyStimulus(4'b0000);
        checkOutput("lim_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(4'b1001);
        checkOutput("lim_wrap", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a grant.
        doReset();
        applyStimulus(4'b1000);
        checkOutput("arst_pre", 4'b1000, 2'd3, 1'b1, 1'b0);
        #2;
        n_reset = 1'b0;
        req     = 4'b1001;
        #1;
        checkOutput("arst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        modelReset();
        @(negedge clk);
        n_reset = 1'b1;
        @(posedge clk);
        modelStep(4'b1001);
        #1;
        checkOutput("arst_first", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Random traffic: requests toggle rarely so most are held for several cycles.
        for (int i = 0; i < NREQ; i++) waitCnt[i] = 0;
        for (int n = 0; n < 2000; n++) begin
            r = req;
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            applyStimulus(r);
            checkOutput("rand_model", modelGnt(), modelId(), (mOwner >= 0), mTimeout);
            checks++;
            if (!$onehot0(gnt) || busy !== |gnt) begin
                errors++;
                $display("[TB] FAIL rand_onehot: got gnt=%b busy=%b", gnt, busy);
            end
            for (int b = 0; b < NREQ; b++) begin
                if (r[b] && gnt[b]) begin
                    checks++;
                    if (waitCnt[b] > STARVE_BOUND) begin
                        errors++;
                        $display("[TB] FAIL rand_starve: req %0d waited %0d, limit %0d", b, waitCnt[b], STARVE_BOUND);
                    end
                    waitCnt[b] = 0;
                end else if (r[b]) begin
                    waitCnt[b]++;
                end else begin
                    waitCnt[b] = 0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uop_rr_arbiter.md
Name: uop_rr_arbiter

Overview:
Round-robin arbiter that shares one resource, such as a single OR-gate datapath or a shared bus, between N requesters.
- Grants are one-hot and registered.
- A grant is held while the owner keeps its request asserted.
- A hold-time limit forces release so that no requester can starve the others.
- Sits between requester FSMs and the shared datapath's input mux; gnt_id drives that mux select directly.

Parameters:
N, 4, number of requesters (2..16)
MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant (>=2)
IDW, $clog2(N), width of gnt_id (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
n_reset  input  1  asynchronous active-low reset
req  input  N  request level per requester; held high while resource wanted
gnt  output  N  one-hot grant, registered; all-zero when idle
gnt_id  output  IDW  index of current owner; 0 when idle
busy  output  1  high while any grant is active (equals |gnt)
timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD

Behaviour:
- Interface: one clock, clk. Reset n_reset is asynchronous and active-low. All state is cleared immediately when n_reset is low, independent of clk.
- Reset values: gnt=0, gnt_id=0, busy=0, timeout=0, state=IDLE, ptr=0, hold_cnt=0.
- FSM states: IDLE and GRANT.
- IDLE:
  - If req!=0, pick the first set bit at or after ptr, searching upward with wrap N-1 -> 0.
  - Register that winner into gnt/gnt_id, clear hold_cnt, and go to GRANT.
  - Latency: req high at edge k, gnt high after edge k+1.
  - If req==0, stay in IDLE.
- GRANT:
  - hold_cnt increments each cycle, starting at 0 in the first grant cycle.
  - Normal release: if req[gnt_id]==0, then at the next edge gnt=0, ptr=(gnt_id+1) mod N, state=IDLE, timeout stays 0.
  - Forced release: if req[gnt_id]==1 and hold_cnt==MAX_HOLD-1, then at the next edge gnt=0, ptr=(gnt_id+1) mod N, state=IDLE, timeout=1 for exactly one cycle.
  - Otherwise hold gnt unchanged. Requests from non-owners are ignored while in GRANT.
- Grant durations:
  - A grant lasts at most MAX_HOLD cycles.
  - Every grant is followed by exactly one IDLE cycle with gnt=0 (bus turnaround gap).
- Fairness: after a release the owner has lowest priority. It is re-granted only if no other req bit is set in that IDLE cycle.
- Simultaneous events:
  - If the owner drops req in the same cycle the limit is reached, treat it as a normal release (timeout=0).
  - Multiple new requests in IDLE are resolved by ptr order only.
- Reset mid-grant: gnt drops asynchronously, and ptr returns to 0.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_id is consistent with gnt.
  - busy==|gnt.
  - timeout never asserts in IDLE except in the cycle immediately after a forced release, when state is already IDLE.

Decomposition:
- Package uop_arb_pkg holds:
  - typedef enum logic {IDLE, GRANT} arb_state_t;
  - a localparam default for MAX_HOLD.
- One combinational sub-module, uop_rr_pick (parameter N), with ports: input req[N], input ptr[IDW], output valid, output idx[IDW].
  - Function: rotating priority search.
  - Implementation: rotate req right by ptr, fixed-priority encode, then add ptr mod N.
- uop_rr_arbiter holds the FSM, hold_cnt, ptr and the output registers.

Test Plan:
1. Reset, then drive req=4'b0100 for 3 cycles and drop it. Expected: gnt=4'b0100 and gnt_id=2 starting one cycle after req, for 3 cycles; one idle cycle; ptr=3; timeout never asserted.
2. Round-robin: from reset, hold req=4'b1111 constantly with MAX_HOLD=8. Expected: grants in order 0,1,2,3,0. Each grant lasts 8 cycles, ends with a timeout pulse, and is separated by 1 idle cycle.
3. Fairness: requester 1 releases while req=4'b0011 is held. Expected: next grant goes to requester 0, not 1. With req=4'b0010 only, requester 1 is re-granted after the idle gap.
4. Boundary: owner 3 drops req in the same cycle hold_cnt==7. Expected: normal release with timeout=0, and ptr wraps to 0.
5. Asynchronous reset mid-grant: assert n_reset low between clock edges while gnt=4'b1000. Expected: gnt=0, busy=0 and gnt_id=0 immediately, before the next edge. After release with req=4'b1001, requester 0 is granted first.
6. Randomised req for 2000 cycles with assertions: gnt one-hot or zero; busy==|gnt; no grant exceeds MAX_HOLD cycles; every requester held high is granted within N*(MAX_HOLD+1) cycles.
